// File: rtl/usb_pkt_fifo.sv
// usb_pkt_fifo: synchronous packet FIFO with speculative write, commit/discard
// and first-word-fall-through read from a synchronous block RAM.
// Writers push speculatively; only committed words ever reach the read side.
module usb_pkt_fifo #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 6,
   parameter int AFULL_THR = 56
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_push_i,
   input  logic              wr_commit_i,
   input  logic              wr_discard_i,
   output logic              wr_full_o,
   output logic              almost_full_o,
   output logic [ADDR_W:0]   wr_level_o,
   output logic              drop_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   input  logic              rd_pop_i,
   output logic [ADDR_W:0]   rd_level_o,
   output logic              ovf_o,
   output logic              udf_o,
   input  logic              err_clr_i
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int PW    = ADDR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];

   // wr_ptr: speculative tail, cm_ptr: committed tail, rd_ptr: head.
   // cm_vis is cm_ptr one cycle late; it paces when committed words become visible.
   logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr, cm_vis;
   logic [PW-1:0] wr_level, rd_level, wr_ptr_inc, rd_ptr_nxt;
   logic          pkt_bad, drop, ovf, udf, rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic          full, live;
   logic          push_ok, push_drop, bad_now;
   logic          commit_ok, commit_drop, pop_ok, pop_udf;

   assign wr_level = wr_ptr - rd_ptr;
   assign rd_level = cm_ptr - rd_ptr;
   assign full     = (wr_level == PW'(DEPTH));

   // flush_i masks every other request; discard masks push and commit.
   assign live       = ~flush_i;
   assign push_ok    = live & wr_push_i & ~wr_discard_i & ~full;
   assign push_drop  = live & wr_push_i & ~wr_discard_i & full;
   // An overflow in the same cycle as the commit already corrupts the packet.
   assign bad_now    = pkt_bad | push_drop;
   assign commit_ok   = live & wr_commit_i & ~wr_discard_i & ~bad_now;
   assign commit_drop = live & wr_commit_i & ~wr_discard_i & bad_now;
   assign pop_ok     = live & rd_pop_i & rd_valid;
   assign pop_udf    = live & rd_pop_i & ~rd_valid;

   assign wr_ptr_inc = wr_ptr + PW'(push_ok);
   assign rd_ptr_nxt = rd_ptr + PW'(pop_ok);

   // Pointer updates: flush clears, discard or bad commit rewinds the tail.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         cm_ptr <= '0;
         rd_ptr <= '0;
         cm_vis <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         cm_ptr <= '0;
         rd_ptr <= '0;
         cm_vis <= '0;
      end else begin
         if (wr_discard_i || commit_drop) wr_ptr <= cm_ptr;
         else                             wr_ptr <= wr_ptr_inc;
         if (commit_ok) cm_ptr <= wr_ptr_inc;
         rd_ptr <= rd_ptr_nxt;
         cm_vis <= cm_ptr;
      end
   end

   // Packet-bad tracking, drop pulse and sticky error flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pkt_bad <= 1'b0;
         drop    <= 1'b0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
      end else if (flush_i) begin
         pkt_bad <= 1'b0;
         drop    <= 1'b0;
      end else begin
         if (wr_commit_i || wr_discard_i) pkt_bad <= 1'b0;
         else if (push_drop)              pkt_bad <= 1'b1;
         // A bad commit with nothing speculative is a plain no-op.
         drop <= commit_drop & (wr_ptr_inc != cm_ptr);
         ovf  <= push_drop | (ovf & ~err_clr_i);
         udf  <= pop_udf   | (udf & ~err_clr_i);
      end
   end

   // RAM write port, no reset on storage.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= wr_data_i;
   end

   // FWFT output register: prefetch the next head while popping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_data  <= mem[rd_ptr_nxt[ADDR_W-1:0]];
         rd_valid <= live & (cm_vis != rd_ptr_nxt);
      end
   end

   assign wr_full_o     = full;
   assign almost_full_o = (wr_level >= PW'(AFULL_THR));
   assign wr_level_o    = wr_level;
   assign rd_level_o    = rd_level;
   assign drop_o        = drop;
   assign rd_data_o     = rd_data;
   assign rd_valid_o    = rd_valid;
   assign ovf_o         = ovf;
   assign udf_o         = udf;

endmodule

// File: tb/tb_usb_pkt_fifo.sv
// tb_usb_pkt_fifo: directed scenarios plus random traffic against a queue model.
module tb_usb_pkt_fifo;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       flush_i, wr_push_i, wr_commit_i, wr_discard_i, rd_pop_i, err_clr_i;
   logic [7:0] wr_data_i;
   logic       wr_full_o, almost_full_o, drop_o, rd_valid_o, ovf_o, udf_o;
   logic [6:0] wr_level_o, rd_level_o;
   logic [7:0] rd_data_o;

   int checks = 0;
   int errors = 0;

   usb_pkt_fifo dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .wr_data_i(wr_data_i), .wr_push_i(wr_push_i), .wr_commit_i(wr_commit_i),
      .wr_discard_i(wr_discard_i), .wr_full_o(wr_full_o), .almost_full_o(almost_full_o),
      .wr_level_o(wr_level_o), .drop_o(drop_o), .rd_data_o(rd_data_o),
      .rd_valid_o(rd_valid_o), .rd_pop_i(rd_pop_i), .rd_level_o(rd_level_o),
      .ovf_o(ovf_o), .udf_o(udf_o), .err_clr_i(err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   // Model: speculative bytes, committed bytes stamped with their commit edge.
   typedef struct {
      logic [7:0] d;
      int         st;
   } cent_t;

   logic [7:0] sq[$];
   cent_t      cq[$];
   bit         m_bad, m_ovf, m_udf, m_drop;
   int         cyc = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // A committed word is readable two edges after the edge that committed it.
   function automatic bit m_valid();
      return cq.size() > 0 && cq[0].st + 2 <= cyc;
   endfunction

   task automatic check_all();
      int lvl;
      lvl = sq.size() + cq.size();
      chk("wr_level", 32'(wr_level_o), lvl);
      chk("rd_level", 32'(rd_level_o), cq.size());
      chk("wr_full", 32'(wr_full_o), 32'(lvl == 64));
      chk("almost_full", 32'(almost_full_o), 32'(lvl >= 56));
      chk("rd_valid", 32'(rd_valid_o), 32'(m_valid()));
      chk("drop", 32'(drop_o), 32'(m_drop));
      chk("ovf", 32'(ovf_o), 32'(m_ovf));
      chk("udf", 32'(udf_o), 32'(m_udf));
      if (m_valid()) chk("rd_data", 32'(rd_data_o), 32'(cq[0].d));
   endtask

   task automatic model_clear();
      sq.delete();
      cq.delete();
      m_bad = 0; m_ovf = 0; m_udf = 0; m_drop = 0;
   endtask

   // One clock: drive inputs, advance the model across the edge, compare.
   task automatic step(input bit fl, input bit pu, input logic [7:0] d,
                       input bit co, input bit di, input bit po, input bit ec);
      bit v, full, pdrop, udset, bad;
      flush_i = fl; wr_push_i = pu; wr_data_i = d; wr_commit_i = co;
      wr_discard_i = di; rd_pop_i = po; err_clr_i = ec;
      full = (sq.size() + cq.size()) == 64;
      v = m_valid();
      @(posedge clk_i);
      cyc++;
      m_drop = 0;
      if (fl) begin
         sq.delete();
         cq.delete();
         m_bad = 0;
      end else begin
         udset = 0;
         pdrop = 0;
         if (po) begin
            if (v) void'(cq.pop_front());
            else   udset = 1;
         end
         if (pu && !di) begin
            if (full) pdrop = 1;
            else      sq.push_back(d);
         end
         bad = m_bad | pdrop;
         if (di) begin
            sq.delete();
            m_bad = 0;
         end else if (co) begin
            if (bad) begin
               if (sq.size() > 0) m_drop = 1;
            end else begin
               foreach (sq[i]) cq.push_back('{sq[i], cyc});
            end
            sq.delete();
            m_bad = 0;
         end else begin
            m_bad = bad;
         end
         m_ovf = pdrop | (m_ovf & !ec);
         m_udf = udset | (m_udf & !ec);
      end
      #1;
      check_all();
   endtask

   task automatic idle();
      step(0, 0, 8'h00, 0, 0, 0, 0);
   endtask

   initial begin
      rst_ni = 1'b0;
      flush_i = 0; wr_push_i = 0; wr_data_i = '0; wr_commit_i = 0;
      wr_discard_i = 0; rd_pop_i = 0; err_clr_i = 0;
      model_clear();
      #12;
      check_all();
      chk("rst_data", 32'(rd_data_o), 0);
      @(negedge clk_i) rst_ni = 1'b1;
      @(posedge clk_i) #1;

      // 1: speculative words stay hidden until commit, then appear two edges later
      step(0, 1, 8'hA1, 0, 0, 0, 0);
      step(0, 1, 8'hA2, 0, 0, 0, 0);
      step(0, 1, 8'hA3, 0, 0, 0, 0);
      chk("t1_wr_level", 32'(wr_level_o), 3);
      chk("t1_rd_level", 32'(rd_level_o), 0);
      chk("t1_valid_spec", 32'(rd_valid_o), 0);
      step(0, 0, 8'h00, 1, 0, 0, 0);
      chk("t1_valid_n", 32'(rd_valid_o), 0);
      idle();
      chk("t1_valid_n1", 32'(rd_valid_o), 0);
      idle();
      chk("t1_valid_n2", 32'(rd_valid_o), 1);
      chk("t1_head", 32'(rd_data_o), 32'h A1);
      repeat (3) step(0, 0, 8'h00, 0, 0, 1, 0);

      // 2: full packet of 64 with commit on the last push, then streaming pops
      for (int i = 0; i < 64; i++) step(0, 1, 8'(i * 3 + 7), i == 63, 0, 0, 0);
      chk("t2_full", 32'(wr_full_o), 1);
      idle();
      idle();
      step(0, 0, 8'h00, 0, 0, 1, 0);
      chk("t2_full_after_pop", 32'(wr_full_o), 0);
      for (int i = 1; i < 64; i++) step(0, 0, 8'h00, 0, 0, 1, 0);
      chk("t2_drained", 32'(rd_level_o), 0);

      // 3: discarded packet leaves no trace
      for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h50 + i), 0, 0, 0, 0);
      step(0, 0, 8'h00, 0, 1, 0, 0);
      step(0, 1, 8'hB0, 0, 0, 0, 0);
      step(0, 1, 8'hB1, 0, 0, 0, 0);
      step(0, 0, 8'h00, 1, 0, 0, 0);
      chk("t3_rd_level", 32'(rd_level_o), 2);
      idle();
      idle();
      chk("t3_head", 32'(rd_data_o), 32'h B0);
      step(0, 0, 8'h00, 0, 0, 1, 0);
      chk("t3_second", 32'(rd_data_o), 32'h B1);
      step(0, 0, 8'h00, 0, 0, 1, 0);
      chk("t3_empty", 32'(rd_level_o), 0);

      // 4: overflow marks the packet bad, so its commit becomes a drop
      for (int i = 0; i < 64; i++) step(0, 1, 8'(i), 0, 0, 0, 0);
      step(0, 1, 8'hEE, 0, 0, 0, 0);
      chk("t4_ovf", 32'(ovf_o), 1);
      step(0, 0, 8'h00, 1, 0, 0, 0);
      chk("t4_drop", 32'(drop_o), 1);
      chk("t4_level", 32'(wr_level_o), 0);
      idle();
      chk("t4_drop_pulse", 32'(drop_o), 0);
      idle();
      chk("t4_no_read", 32'(rd_valid_o), 0);

      // 5: underflow, error clear, flush mid-packet
      step(0, 0, 8'h00, 0, 0, 1, 0);
      chk("t5_udf", 32'(udf_o), 1);
      step(0, 0, 8'h00, 0, 0, 0, 1);
      chk("t5_udf_clr", 32'(udf_o), 0);
      chk("t5_ovf_clr", 32'(ovf_o), 0);
      for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h30 + i), i == 9, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h70 + i), 0, 0, 0, 0);
      step(1, 0, 8'h00, 0, 0, 0, 0);
      chk("t5_flush_wr", 32'(wr_level_o), 0);
      chk("t5_flush_rd", 32'(rd_level_o), 0);
      chk("t5_flush_valid", 32'(rd_valid_o), 0);

      // 6: asynchronous reset mid-stream
      for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h90 + i), i == 5, 0, 0, 0);
      idle();
      idle();
      #3 rst_ni = 1'b0;
      #1;
      model_clear();
      check_all();
      chk("t6_rst_data", 32'(rd_data_o), 0);
      @(negedge clk_i) rst_ni = 1'b1;
      @(posedge clk_i) #1;

      // random traffic against the model
      for (int i = 0; i < 200; i++) begin
         step($urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 65,
              8'($urandom),
              $urandom_range(0, 99) < 12,
              $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 5);
      end
      // drain whatever is committed
      for (int i = 0; i < 80; i++) step(0, 0, 8'h00, i == 0, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
